md_sched: RTL

Multiply/divide scheduler for the pipelined MIPS core. Accepts mult/multu/div/divu/mthi/mtlo from the E stage, owns the HI/LO registers, models the multi-cycle latency of the shared multiply/divide resource and raises a stall for any D-stage HI/LO-class instruction that would collide with a busy unit. It sits beside the ALU in E; mfhi/mflo read `hi`/`lo` directly.

---
 rtl/md_pkg.sv | 46 ++++
 rtl/md_arith.sv | 65 ++++++
 rtl/md_sched.sv | 128 ++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared encodings for the multiply/divide scheduler.
// Optional feature macro: MD_MADD_EN (enables MADD/MADDU accumulate ops).
package md_pkg;

    localparam int CNT_W = 5;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } md_state_e;

    // Ops that occupy the unit for the multiply latency.
    function automatic logic is_mul_op(input logic [3:0] op);
        logic r;
        case (op)
            OP_MULT, OP_MULTU: r = 1'b1;
`ifdef MD_MADD_EN
            OP_MADD, OP_MADDU: r = 1'b1;
`endif
            default:           r = 1'b0;
        endcase
        return r;
    endfunction

    // Ops that occupy the unit for the divide latency.
    function automatic logic is_div_op(input logic [3:0] op);
        logic r;
        case (op)
            OP_DIV, OP_DIVU: r = 1'b1;
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: combinational 64-bit {hi,lo} result for the latched op.
// Divide by zero returns the current {hi,lo} so the commit is a no-op.
// Optional feature macro: MD_MADD_EN (adds the 64-bit accumulate path).
module md_arith
    import md_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [63:0] acc,
    output logic [63:0] result
);

    logic [63:0] uprod_s;
    logic [63:0] sprod_s;
    logic [31:0] abs_a_s;
    logic [31:0] abs_b_s;
    logic [31:0] mag_q_s;
    logic [31:0] mag_r_s;
    logic [31:0] sq_s;
    logic [31:0] sr_s;
    logic [31:0] uq_s;
    logic [31:0] ur_s;
    logic        b_zero_s;

    // Low 64 bits of the sign-extended product equal the signed product.
    assign uprod_s  = {32'd0, a} * {32'd0, b};
    assign sprod_s  = {{32{a[31]}}, a} * {{32{b[31]}}, b};

    // Signed divide via magnitudes: quotient truncates toward zero,
    // remainder takes the dividend sign; 0x80000000/-1 falls out as
    // quotient 0x80000000, remainder 0 without a special case.
    assign abs_a_s  = a[31] ? (~a + 32'd1) : a;
    assign abs_b_s  = b[31] ? (~b + 32'd1) : b;
    assign b_zero_s = (b == 32'd0);
    assign mag_q_s  = b_zero_s ? 32'd0 : (abs_a_s / abs_b_s);
    assign mag_r_s  = b_zero_s ? 32'd0 : (abs_a_s % abs_b_s);
    assign sq_s     = (a[31] ^ b[31]) ? (~mag_q_s + 32'd1) : mag_q_s;
    assign sr_s     = a[31] ? (~mag_r_s + 32'd1) : mag_r_s;
    assign uq_s     = b_zero_s ? 32'd0 : (a / b);
    assign ur_s     = b_zero_s ? 32'd0 : (a % b);

    // Select the committed {hi,lo} value for the latched op.
    always_comb begin
        result = acc;
        case (op)
            OP_MULT:  result = sprod_s;
            OP_MULTU: result = uprod_s;
            OP_DIV: begin
                if (b_zero_s) result = acc;
                else          result = {sr_s, sq_s};
            end
            OP_DIVU: begin
                if (b_zero_s) result = acc;
                else          result = {ur_s, uq_s};
            end
`ifdef MD_MADD_EN
            OP_MADD:  result = acc + sprod_s;
            OP_MADDU: result = acc + uprod_s;
`endif
            default:  result = acc;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// md_sched: HI/LO owner and multi-cycle mult/div scheduler for the E stage.
// A started op holds the unit for MULT_CYCLES/DIV_CYCLES cycles, then
// commits {hi,lo} and pulses done. stall keeps HI/LO-class D-stage
// instructions out of E while the unit is (or is about to be) busy.
// Optional feature macro: MD_MADD_EN (MADD/MADDU accumulate).
module md_sched
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        cancel,
    input  logic        d_md_use,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e        state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [3:0]       op_r, op_s;
    logic [31:0]      a_r, a_s;
    logic [31:0]      b_r, b_s;
    logic [31:0]      hi_r, hi_s;
    logic [31:0]      lo_r, lo_s;
    logic             done_r, done_s;
    logic [63:0]      result_s;
    logic             take_s;

    md_arith u_arith (
        .op     (op_r),
        .a      (a_r),
        .b      (b_r),
        .acc    ({hi_r, lo_r}),
        .result (result_s)
    );

    assign take_s = start & ~cancel;

    // Next-state, counter, latch and HI/LO update logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        op_s    = op_r;
        a_s     = a_r;
        b_s     = b_r;
        hi_s    = hi_r;
        lo_s    = lo_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (take_s) begin
                    if (is_mul_op(md_op)) begin
                        op_s    = md_op;
                        a_s     = rs_val;
                        b_s     = rt_val;
                        cnt_s   = CNT_W'(MULT_CYCLES - 1);
                        state_s = MUL;
                    end else if (is_div_op(md_op)) begin
                        op_s    = md_op;
                        a_s     = rs_val;
                        b_s     = rt_val;
                        cnt_s   = CNT_W'(DIV_CYCLES - 1);
                        state_s = DIV;
                    end else if (md_op == OP_MTHI) begin
                        hi_s = rs_val;
                    end else if (md_op == OP_MTLO) begin
                        lo_s = rs_val;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            MUL, DIV: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    hi_s    = result_s[63:32];
                    lo_s    = result_s[31:0];
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            op_r    <= OP_NONE;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            op_r    <= op_s;
            a_r     <= a_s;
            b_r     <= b_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
            done_r  <= done_s;
        end
    end

    assign busy  = (state_r != IDLE);
    assign done  = done_r;
    assign hi    = hi_r;
    assign lo    = lo_r;
    assign stall = d_md_use &
                   (busy | (take_s & (is_mul_op(md_op) | is_div_op(md_op))));

endmodule
